// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared 64 KiB x 8 memory.
// Grants one valid/ready request at a time, holds the access for WAIT_CYCLES, then pulses a response.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                state_r;
  state_t                next_state_s;
  logic [3:0]            cnt_r;
  logic                  last_grant_r;
  logic                  grant_r;
  logic                  ready0_s;
  logic                  ready1_s;
  logic                  accept_s;
  logic                  finish_s;
  logic                  rsp0_valid_r;
  logic                  rsp1_valid_r;
  logic                  busy_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;

  // Arbitration and next-state logic; ready is suppressed while reset is held.
  always_comb begin
    ready0_s     = 1'b0;
    ready1_s     = 1'b0;
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        ready0_s = rst_n & req0_valid & (~req1_valid | last_grant_r);
        ready1_s = rst_n & req1_valid & (~req0_valid | ~last_grant_r);
        if (ready0_s || ready1_s) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ACCESS;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  assign accept_s = (state_r == IDLE) && (ready0_s || ready1_s);
  assign finish_s = (state_r == ACCESS) && (cnt_r == 4'd0);

  // State, grant bookkeeping, wait counter and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      busy_r       <= (next_state_s != IDLE);
      rsp0_valid_r <= finish_s & ~grant_r;
      rsp1_valid_r <= finish_s & grant_r;
      if (accept_s) begin
        grant_r <= ready1_s;
        cnt_r   <= CNT_LOAD;
      end else if (state_r == ACCESS && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (finish_s) begin
        last_grant_r <= grant_r;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Memory-side datapath: address and data hold their last values outside an access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        mem_addr_r  <= ready1_s ? req1_addr  : req0_addr;
        mem_wdata_r <= ready1_s ? req1_wdata : req0_wdata;
        mem_we_r    <= ready1_s ? req1_we    : req0_we;
      end else if (finish_s) begin
        mem_we_r    <= 1'b0;
        rsp_rdata_r <= mem_read_data;
      end else begin
        mem_we_r <= mem_we_r;
      end
    end
  end

  assign req0_ready       = ready0_s;
  assign req1_ready       = ready1_s;
  assign rsp0_valid       = rsp0_valid_r;
  assign rsp1_valid       = rsp1_valid_r;
  assign rsp_rdata        = rsp_rdata_r;
  assign mem_address      = mem_addr_r;
  assign mem_write_data   = mem_wdata_r;
  assign mem_write_enable = mem_we_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a (WAIT_CYCLES=1) on a memory model,
// instance b (WAIT_CYCLES=4) on a single-location read stub.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  int          checks;
  int          failures;

  logic        a_v0, a_we0, a_v1, a_we1;
  logic [15:0] a_addr0, a_addr1;
  logic [7:0]  a_wd0, a_wd1;
  logic        a_rdy0, a_rdy1, a_rsp0, a_rsp1, a_busy, a_mwe;
  logic [7:0]  a_rdata, a_mwd, a_mrd;
  logic [15:0] a_maddr;

  logic        b_v0;
  logic [15:0] b_addr0;
  logic        b_rdy0, b_rdy1, b_rsp0, b_rsp1, b_busy, b_mwe;
  logic [7:0]  b_rdata, b_mwd, b_mrd;
  logic [15:0] b_maddr;

  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  mem_a [0:65535];

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_we(a_we0), .req0_addr(a_addr0), .req0_wdata(a_wd0), .req0_ready(a_rdy0),
    .req1_valid(a_v1), .req1_we(a_we1), .req1_addr(a_addr1), .req1_wdata(a_wd1), .req1_ready(a_rdy1),
    .rsp0_valid(a_rsp0), .rsp1_valid(a_rsp1), .rsp_rdata(a_rdata),
    .mem_address(a_maddr), .mem_write_data(a_mwd), .mem_write_enable(a_mwe),
    .mem_read_data(a_mrd), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_we(1'b0), .req0_addr(b_addr0), .req0_wdata(8'h00), .req0_ready(b_rdy0),
    .req1_valid(1'b0), .req1_we(1'b0), .req1_addr(16'h0000), .req1_wdata(8'h00), .req1_ready(b_rdy1),
    .rsp0_valid(b_rsp0), .rsp1_valid(b_rsp1), .rsp_rdata(b_rdata),
    .mem_address(b_maddr), .mem_write_data(b_mwd), .mem_write_enable(b_mwe),
    .mem_read_data(b_mrd), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (a_mwe) mem_a[a_maddr] <= a_mwd;
  end
  assign a_mrd = mem_a[a_maddr];
  assign b_mrd = (b_maddr == 16'hFFFF) ? 8'h5C : 8'h00;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    a_v0 = 1'b0; a_we0 = 1'b0; a_addr0 = 16'h0000; a_wd0 = 8'h00;
    a_v1 = 1'b0; a_we1 = 1'b0; a_addr1 = 16'h0000; a_wd1 = 8'h00;
    b_v0 = 1'b0; b_addr0 = 16'h0000;
    pl_en = 1'b1; pl_addr = 16'h0000; pl_data = 8'hAA;
    tick;
    pl_addr = 16'h0003; pl_data = 8'h33;
    tick;
    pl_en = 1'b0;
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_we", a_mwe, 1'b0);
    chk("rst_addr", a_maddr, 16'h0000);
    chk("rst_wdata", a_mwd, 8'h00);
    chk("rst_rdata", a_rdata, 8'h00);
    chk("rst_rsp", {a_rsp0, a_rsp1, a_rdy0, a_rdy1}, 4'b0000);
    rst_n = 1'b1;
    tick;

    // single read of 0x0000
    a_v0 = 1'b1; a_addr0 = 16'h0000; a_we0 = 1'b0;
    #1;
    chk("t1_ready", {a_rdy0, a_rdy1}, 2'b10);
    chk("t1_busy_n", a_busy, 1'b0);
    tick;
    a_v0 = 1'b0;
    #1;
    chk("t1_busy_n1", a_busy, 1'b1);
    chk("t1_rsp_n1", {a_rsp0, a_rsp1}, 2'b00);
    chk("t1_addr_n1", a_maddr, 16'h0000);
    tick;
    chk("t1_rsp_n2", {a_rsp0, a_rsp1}, 2'b10);
    chk("t1_rdata", a_rdata, 8'hAA);
    chk("t1_busy_n2", a_busy, 1'b1);
    tick;
    chk("t1_rsp_n3", {a_rsp0, a_rsp1}, 2'b00);
    chk("t1_busy_n3", a_busy, 1'b0);

    // port 1 writes 0xBB to 0x0001
    a_v1 = 1'b1; a_we1 = 1'b1; a_addr1 = 16'h0001; a_wd1 = 8'hBB;
    #1;
    chk("t2_ready", {a_rdy0, a_rdy1}, 2'b01);
    chk("t2_we_before", a_mwe, 1'b0);
    tick;
    a_v1 = 1'b0; a_we1 = 1'b0;
    #1;
    chk("t2_we_access", a_mwe, 1'b1);
    chk("t2_addr_access", a_maddr, 16'h0001);
    chk("t2_wdata_access", a_mwd, 8'hBB);
    tick;
    chk("t2_we_done", a_mwe, 1'b0);
    chk("t2_addr_done", a_maddr, 16'h0001);
    chk("t2_rsp_done", {a_rsp0, a_rsp1}, 2'b01);
    tick;
    chk("t2_addr_idle", a_maddr, 16'h0001);
    chk("t2_we_idle", a_mwe, 1'b0);
    a_v0 = 1'b1; a_addr0 = 16'h0001;
    #1;
    chk("t2_rd1_ready", a_rdy0, 1'b1);
    tick;
    a_v0 = 1'b0;
    tick;
    chk("t2_rd1_rsp", a_rsp0, 1'b1);
    chk("t2_rd1_data", a_rdata, 8'hBB);
    tick;
    a_v0 = 1'b1; a_addr0 = 16'h0000;
    tick;
    a_v0 = 1'b0;
    tick;
    chk("t2_rd0_rsp", a_rsp0, 1'b1);
    chk("t2_rd0_data", a_rdata, 8'hAA);
    tick;

    // simultaneous requests from reset alternate 0,1,0
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    a_v0 = 1'b1; a_addr0 = 16'h0000;
    a_v1 = 1'b1; a_addr1 = 16'h0001; a_we1 = 1'b0;
    #1;
    chk("t3_g0_ready", {a_rdy0, a_rdy1}, 2'b10);
    tick;
    chk("t3_access_ready", {a_rdy0, a_rdy1}, 2'b00);
    tick;
    chk("t3_done_ready", {a_rdy0, a_rdy1}, 2'b00);
    chk("t3_rsp0", {a_rsp0, a_rsp1}, 2'b10);
    chk("t3_rsp0_data", a_rdata, 8'hAA);
    tick;
    chk("t3_g1_ready", {a_rdy0, a_rdy1}, 2'b01);
    tick;
    tick;
    chk("t3_rsp1", {a_rsp0, a_rsp1}, 2'b01);
    chk("t3_rsp1_data", a_rdata, 8'hBB);
    tick;
    chk("t3_g2_ready", {a_rdy0, a_rdy1}, 2'b10);
    a_v0 = 1'b0; a_v1 = 1'b0;
    tick;
    chk("t3_idle_busy", a_busy, 1'b0);

    // reset during the first ACCESS cycle of a write
    a_v1 = 1'b1; a_we1 = 1'b1; a_addr1 = 16'h0002; a_wd1 = 8'h11;
    #1;
    chk("t5_ready", a_rdy1, 1'b1);
    tick;
    a_v1 = 1'b0; a_we1 = 1'b0;
    a_v0 = 1'b1; a_addr0 = 16'h0000;
    #1;
    chk("t5_we_access", a_mwe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_we_rst", a_mwe, 1'b0);
    chk("t5_busy_rst", a_busy, 1'b0);
    chk("t5_ready_rst", {a_rdy0, a_rdy1}, 2'b00);
    chk("t5_rsp_rst", {a_rsp0, a_rsp1}, 2'b00);
    tick;
    rst_n = 1'b1;
    #1;
    chk("t5_ready_after", a_rdy0, 1'b1);
    tick;
    a_v0 = 1'b0;
    tick;
    chk("t5_rsp_after", {a_rsp0, a_rsp1}, 2'b10);
    chk("t5_data_after", a_rdata, 8'hAA);
    tick;

    // port 1 valid withdrawn while busy
    a_v0 = 1'b1; a_addr0 = 16'h0000;
    #1;
    chk("t6_ready0", a_rdy0, 1'b1);
    tick;
    a_v0 = 1'b0;
    a_v1 = 1'b1; a_we1 = 1'b1; a_addr1 = 16'h0003; a_wd1 = 8'h77;
    #1;
    chk("t6_ready1_access", a_rdy1, 1'b0);
    tick;
    chk("t6_rsp0", {a_rsp0, a_rsp1}, 2'b10);
    a_v1 = 1'b0; a_we1 = 1'b0;
    tick;
    chk("t6_idle", {a_busy, a_rdy1, a_rsp1, a_mwe}, 4'b0000);
    tick;
    chk("t6_still_idle", {a_busy, a_rsp1}, 2'b00);
    a_v0 = 1'b1; a_addr0 = 16'h0003;
    tick;
    a_v0 = 1'b0;
    tick;
    chk("t6_rd3_rsp", {a_rsp0, a_rsp1}, 2'b10);
    chk("t6_rd3_data", a_rdata, 8'h33);
    tick;

    // WAIT_CYCLES=4 read of 0xFFFF
    b_v0 = 1'b1; b_addr0 = 16'hFFFF;
    #1;
    chk("t4_ready", {b_rdy0, b_rdy1}, 2'b10);
    tick;
    b_v0 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4_busy_n%0d", i), b_busy, 1'b1);
      chk($sformatf("t4_addr_n%0d", i), b_maddr, 16'hFFFF);
      chk($sformatf("t4_rsp_n%0d", i), {b_rsp0, b_rsp1}, 2'b00);
      tick;
    end
    chk("t4_rsp_n5", {b_rsp0, b_rsp1}, 2'b10);
    chk("t4_data_n5", b_rdata, 8'h5C);
    chk("t4_addr_n5", b_maddr, 16'hFFFF);
    chk("t4_we_n5", b_mwe, 1'b0);
    tick;
    chk("t4_end", {b_rsp0, b_busy}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
